// File: rtl/elevator_if.sv
// Elevator controller bus: call inputs and passenger count toward the
// controller, position/status/pending calls back from it.
interface elevator_if #(
  parameter int NUM_FLOORS = 8
);
  localparam int CW = $clog2(NUM_FLOORS);

  logic [NUM_FLOORS-1:0] req;
  logic [3:0]            passengers;
  logic [CW-1:0]         current;
  logic                  direction;
  logic                  moving;
  logic                  door_open;
  logic [NUM_FLOORS-1:0] pending;
  logic                  ovld;

  modport master (
    output req, passengers,
    input  current, direction, moving, door_open, pending, ovld
  );

  modport slave (
    input  req, passengers,
    output current, direction, moving, door_open, pending, ovld
  );
endinterface

// File: rtl/elevator_ctrl.sv
// Single-car SCAN elevator controller (IDLE / MOVE / DOOR).
// Optional feature: define ELEV_OVLD_EN to enable the overload flag, which
// holds the door open and keeps the car parked while passengers > MAX_LOAD.
// Without it, ovld is constant 0 and passengers is ignored.
module elevator_ctrl #(
  parameter int NUM_FLOORS = 8,
  parameter int MOVE_TICKS = 4,
  parameter int DOOR_TICKS = 3,
  parameter int MAX_LOAD   = 4
) (
  input  logic       clk,
  input  logic       reset,
  elevator_if.slave  bus
);
  localparam int CW = $clog2(NUM_FLOORS);
  localparam int MW = $clog2(MOVE_TICKS + 1);
  localparam int DW = $clog2(DOOR_TICKS + 1);
  localparam logic [CW-1:0] TOP         = CW'(NUM_FLOORS - 1);
  localparam logic [MW-1:0] MOVE_RELOAD = MW'(MOVE_TICKS - 1);
  localparam logic [DW-1:0] DOOR_RELOAD = DW'(DOOR_TICKS - 1);

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

  state_t                state;
  logic [CW-1:0]         current;
  logic                  direction;
  logic                  moving;
  logic                  door_open;
  logic                  ovld;
  logic [NUM_FLOORS-1:0] pending;
  logic [NUM_FLOORS-1:0] req_prev;
  logic [MW-1:0]         move_cnt;
  logic [DW-1:0]         door_cnt;

  logic [NUM_FLOORS-1:0] rise;
  logic [NUM_FLOORS-1:0] set_mask;
  logic [NUM_FLOORS-1:0] cur_bit;
  logic [NUM_FLOORS-1:0] next_bit;
  logic [CW-1:0]         next_floor;
  logic                  door_restart;
  logic                  here_call;
  logic                  arrive_call;
  logic                  calls_ahead;
  logic                  calls_behind;
  logic                  calls_beyond;
  logic                  off_range;

  // Floors strictly above f (wraps to an empty mask at the top floor).
  function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [CW-1:0] f);
    return ~((NUM_FLOORS'(2) << f) - NUM_FLOORS'(1));
  endfunction

  // Floors strictly below f.
  function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [CW-1:0] f);
    return (NUM_FLOORS'(1) << f) - NUM_FLOORS'(1);
  endfunction

  // Call edge detection, door-restart filtering and SCAN look-ahead.
  always_comb begin
    rise         = bus.req & ~req_prev;
    cur_bit      = NUM_FLOORS'(1) << current;
    next_floor   = direction ? current + CW'(1) : current - CW'(1);
    next_bit     = NUM_FLOORS'(1) << next_floor;
    set_mask     = rise;
    door_restart = 1'b0;
    // A call for the open floor re-arms the door instead of queueing.
    if (state == DOOR && (rise & cur_bit) != '0) begin
      door_restart = 1'b1;
      set_mask     = rise & ~cur_bit;
    end
    here_call    = (pending & cur_bit) != '0;
    arrive_call  = (pending & next_bit) != '0;
    calls_ahead  = direction ? ((pending & above_mask(current)) != '0)
                             : ((pending & below_mask(current)) != '0);
    calls_behind = direction ? ((pending & below_mask(current)) != '0)
                             : ((pending & above_mask(current)) != '0);
    calls_beyond = direction ? ((pending & above_mask(next_floor)) != '0)
                             : ((pending & below_mask(next_floor)) != '0);
    off_range    = (direction && current == TOP) || (!direction && current == '0);
  end

  // Main controller: state, position, direction, timers and call latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      current   <= '0;
      direction <= 1'b1;
      moving    <= 1'b0;
      door_open <= 1'b0;
      pending   <= '0;
      req_prev  <= '0;
      move_cnt  <= '0;
      door_cnt  <= '0;
    end else begin
      req_prev <= bus.req;
      // Later assignments in the same cycle override this, so a bit latched
      // and served on the same edge ends up cleared.
      pending  <= pending | set_mask;
      case (state)
        IDLE: begin
          if (here_call) begin
            state     <= DOOR;
            door_open <= 1'b1;
            door_cnt  <= DOOR_RELOAD;
            pending   <= (pending | set_mask) & ~cur_bit;
          end else if (!ovld && calls_ahead) begin
            state    <= MOVE;
            moving   <= 1'b1;
            move_cnt <= MOVE_RELOAD;
          end else if (!ovld && calls_behind) begin
            direction <= ~direction;
            state     <= MOVE;
            moving    <= 1'b1;
            move_cnt  <= MOVE_RELOAD;
          end else if (off_range) begin
            direction <= ~direction;
          end
        end
        MOVE: begin
          if (move_cnt == '0) begin
            current <= next_floor;
            if (arrive_call) begin
              state     <= DOOR;
              moving    <= 1'b0;
              door_open <= 1'b1;
              door_cnt  <= DOOR_RELOAD;
              pending   <= (pending | set_mask) & ~next_bit;
            end else if (calls_beyond) begin
              move_cnt <= MOVE_RELOAD;
            end else begin
              state  <= IDLE;
              moving <= 1'b0;
            end
          end else begin
            move_cnt <= move_cnt - MW'(1);
          end
        end
        DOOR: begin
          if (door_restart || ovld) begin
            door_cnt <= DOOR_RELOAD;
          end else if (door_cnt == '0) begin
            state     <= IDLE;
            door_open <= 1'b0;
          end else begin
            door_cnt <= door_cnt - DW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          moving    <= 1'b0;
          door_open <= 1'b0;
        end
      endcase
    end
  end

`ifdef ELEV_OVLD_EN
  // Overload flag registered from the live passenger count.
  always_ff @(posedge clk) begin
    if (reset) ovld <= 1'b0;
    else       ovld <= int'(bus.passengers) > MAX_LOAD;
  end
`else
  logic unused_passengers;
  assign ovld              = 1'b0;
  assign unused_passengers = ^bus.passengers;
`endif

  assign bus.current   = current;
  assign bus.direction = direction;
  assign bus.moving    = moving;
  assign bus.door_open = door_open;
  assign bus.pending   = pending;
  assign bus.ovld      = ovld;
endmodule

// File: doc/elevator_ctrl.md
ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 8, number of floors (2..16).
REQ-002 SHALL have parameter MOVE_TICKS, default 4, clk cycles to travel one floor (>=1).
REQ-003 SHALL have parameter DOOR_TICKS, default 3, clk cycles the door stays open (>=1).
REQ-004 SHALL have parameter MAX_LOAD, default 4, highest passenger count that is not overload.
REQ-005 SHALL have ports: clk  in  1  clock. It SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have ports: reset  in  1  synchronous active-high reset.
REQ-007 SHALL have ports: req  in  NUM_FLOORS  floor-call pulses, bit i = floor i.
REQ-008 SHALL have ports: passengers  in  4  current passenger count.
REQ-009 SHALL have ports: current  out  $clog2(NUM_FLOORS)  current floor.
REQ-010 SHALL have ports: direction  out  1  1=up, 0=down.
REQ-011 SHALL have ports: moving  out  1  high in MOVE state.
REQ-012 SHALL have ports: door_open  out  1  high in DOOR state.
REQ-013 SHALL have ports: pending  out  NUM_FLOORS  latched outstanding calls.
REQ-014 SHALL have ports: ovld  out  1  overload flag.

Function
REQ-015 SHALL latch req[i] into pending[i] at the posedge sampling it, visible the next cycle; a held req sets it once per assertion, with no double count.
REQ-016 SHALL implement states IDLE, MOVE, DOOR; moving and door_open are registered decodes of state.
REQ-017 IDLE behaviour:
- pending[current] set: go to DOOR and clear that bit.
- Else any pending bit set in the current direction: go to MOVE.
- Else any pending bit set in the opposite direction: flip direction, then go to MOVE.
- Else stay in IDLE.
REQ-018 MOVE behaviour:
- A tick counter counts MOVE_TICKS cycles, then current steps ±1 per direction.
- On arrival, if pending[new] is set: go to DOOR and clear the bit.
- Else if calls remain beyond the new floor in the current direction: stay in MOVE and reload the counter.
- Else go to IDLE.
REQ-019 current SHALL never wrap: at floor 0 downward travel is impossible, and at NUM_FLOORS-1 upward travel is impossible; a direction pointing off-range is flipped in IDLE.
REQ-020 DOOR SHALL last DOOR_TICKS cycles and then return to IDLE; a req for the current floor during DOOR restarts the door timer and is not latched.
REQ-021 A req for the floor currently being passed during MOVE SHALL be latched and served on a later sweep (SCAN order).
REQ-022 Simultaneous req bits SHALL all latch in the same cycle; a latch and a clear of the same bit in the same cycle SHALL resolve to cleared.

Reset
REQ-023 On reset the block SHALL set state=IDLE, current=0, direction=1, pending=0, ovld=0, and clear all counters; reset mid-MOVE or mid-DOOR aborts immediately.
REQ-024 reset SHALL dominate req in the same cycle.

Configuration
REQ-025 With macro ELEV_OVLD_EN defined:
- ovld is registered as (passengers > MAX_LOAD).
- While ovld=1 in DOOR, the door timer holds at reload, so the door stays open.
- IDLE does not leave for MOVE while ovld=1.
REQ-026 Without ELEV_OVLD_EN, ovld SHALL be tied to 0 and passengers ignored.

Verification (NUM_FLOORS=8, MOVE_TICKS=4, DOOR_TICKS=3)
REQ-027 Single call: reset, pulse req[3] -> pending[3]=1 next cycle, MOVE next, current 1/2/3 every 4 cycles, door_open 3 cycles at floor 3, pending[3]=0, then IDLE.
REQ-028 SCAN: at floor 3 moving up, pending[5] and pending[1] set -> door opens at 5, then direction=0, door opens at 1; floor 1 is never served first.
REQ-029 Overload (ELEV_OVLD_EN): passengers=5 during DOOR -> ovld=1 and door_open held for 20 cycles; passengers=4 -> ovld=0, door closes 3 cycles later.
REQ-030 Door restart: req[current] pulsed in the 2nd DOOR cycle -> door_open lasts 3 cycles from that pulse, pending unchanged.
REQ-031 Boundary: pulse req[7] -> travels to 7 with no wrap; then req[0] -> direction flips to 0 and current counts down to 0.
REQ-032 Reset mid-MOVE at current=2 with pending[6] set -> next cycle current=0, pending=0, moving=0, door_open=0.
